// File: rtl/shift_unit_seq.sv
//------------------------------------------------------------------------------
// shift_unit_seq : iterative barrel shifter (SLL/SRL/SRA/ROR), one shamt bit per cycle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_unit_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int KW = $clog2(SHW);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;

  localparam logic [KW-1:0] K_LAST = KW'(SHW - 1);

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [1:0]       mode_q, mode_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic             last_stage;
  logic [SHW-1:0]   amt;
  logic [SHW-1:0]   amt_neg;
  logic [WIDTH-1:0] stage;
  logic [WIDTH-1:0] work_step;

  assign accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_stage = (state_q == S_SHIFT) && (k_q == K_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      work_q   <= '0;
      shamt_q  <= '0;
      mode_q   <= '0;
      fill_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      work_q   <= work_d;
      shamt_q  <= shamt_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      result_q <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: if (last_stage) state_d = S_DONE;
      S_DONE:  state_d = accept ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One stage of the log shifter: move by 2^k when shamt bit k is set
  always_comb begin
    amt     = SHW'(1) << k_q;
    amt_neg = -amt;
    case (mode_q)
      M_SLL:   stage = work_q << amt;
      M_SRL:   stage = work_q >> amt;
      M_SRA:   stage = (work_q >> amt) | (fill_q ? ~({WIDTH{1'b1}} >> amt) : '0);
      default: stage = (work_q >> amt) | (work_q << amt_neg);
    endcase
    work_step = shamt_q[k_q] ? stage : work_q;
  end

  always_comb begin
    k_d      = k_q;
    work_d   = work_q;
    shamt_d  = shamt_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    result_d = result_q;
    if (accept) begin
      work_d  = data_in;
      shamt_d = shamt;
      mode_d  = mode;
      fill_d  = (mode == M_SRA) ? data_in[WIDTH-1] : 1'b0;
      k_d     = '0;
    end else if (state_q == S_SHIFT) begin
      work_d = work_step;
      k_d    = last_stage ? '0 : k_q + KW'(1);
      if (last_stage) result_d = work_step;
    end
  end

  // Outputs
  always_comb begin
    busy   = (state_q == S_SHIFT);
    done   = (state_q == S_DONE);
    result = result_q;
  end

endmodule

`default_nettype wire

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 32, data width; a power of two, 8 to 64.
REQ-002 The module SHALL derive a localparam SHW = log2(WIDTH), the shift-amount width and the iteration count.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a shift operation.
REQ-007 mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-008 data_in  input  WIDTH  operand to shift.
REQ-009 shamt  input  SHW  shift amount, 0 to WIDTH-1.
REQ-010 busy  output  1  high while an operation is iterating.
REQ-011 done  output  1  one-cycle pulse; result is valid.
REQ-012 result  output  WIDTH  shifted value; held until the next accepted start.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE.
- On acceptance, capture data_in into the working register; latch shamt, mode and fill bit (data_in[WIDTH-1] for SRA, else 0).
- Clear stage counter k to 0; next state SHIFT.
REQ-015 start SHALL be ignored while in SHIFT: no recapture, no effect on the operation in flight.
REQ-016 In SHIFT, each cycle SHALL process bit k of the latched shamt.
- If bit k is 1, shift or rotate the working register by 2^k in the latched mode; if 0, hold it.
- k increments each cycle.
- After the cycle with k = SHW-1, next state is DONE.
REQ-017 Shift fill rules SHALL be:
- SLL: fill vacated LSBs with 0.
- SRL: fill vacated MSBs with 0.
- SRA: fill vacated MSBs with the latched fill bit.
- ROR: bits shifted out at the LSB re-enter at the MSB.
REQ-018 Latency SHALL be fixed and independent of shamt and mode.
- start accepted in cycle 0; busy high in cycles 1..SHW; done high in cycle SHW+1.
- For WIDTH=32, done is high in cycle 6.
REQ-019 On DONE entry, result SHALL load the working register; done SHALL be high for exactly that one cycle.
REQ-020 From DONE, the next state SHALL be SHIFT if start is high in that cycle (back-to-back), else IDLE.
REQ-021 result SHALL change only on DONE entry or on reset.
REQ-022 shamt = 0 SHALL yield result = data_in for every mode, with the full latency.
REQ-023 The SRA fill bit SHALL come from the captured operand only; later changes to data_in SHALL have no effect.

Reset
REQ-024 When reset is high at a clock edge, the module SHALL set state IDLE, k = 0, busy = 0, done = 0, result = 0, working register = 0.
REQ-025 Reset SHALL override start in the same cycle.
REQ-026 Reset during SHIFT SHALL abort the operation; done SHALL NOT pulse for the aborted operation.

Verification (WIDTH=32)
REQ-027 SLL: data_in 0x00000001, shamt 31, mode 00 -> result 0x80000000; done in cycle 6; busy high in cycles 1-5.
REQ-028 SRA vs SRL: data_in 0x80000000, shamt 4 -> mode 10 gives 0xF8000000; mode 01 gives 0x08000000.
REQ-029 ROR: data_in 0x000000F1, shamt 4, mode 11 -> 0x1000000F; and shamt 0 with data_in 0xDEADBEEF, any mode -> 0xDEADBEEF, still done in cycle 6.
REQ-030 start pulse with different operands in cycle 3 of an operation -> ignored; result matches the first operation only.
REQ-031 start held high in the DONE cycle with a new operand -> second done exactly 6 cycles after the first; result updates only at the second done.
REQ-032 reset in cycle 3 of an SRA operation -> busy 0 and result 0 the next cycle; no done pulse; a new operation afterwards completes normally.
